sram_burst_reader: RTL and testbench
====================================

# sram_burst_reader

Read-side client for the team's single-port `SRAM` storage block. On a start pulse it reads `length` consecutive words beginning at `baseAddr`. It drives the SRAM address port with `write` held low, and presents the words on a valid/ready output stream at up to one word per cycle, with backpressure. It sits between an `SRAM` instance and downstream compute (PE feeders, output serializers) that consumes stored feature maps or weights.

## Interface
- `A`, default 7: SRAM address width; depth is 2^A words.
- `W`, default 16: word length.

- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `baseAddr`  in  A  first word address; sampled with `start`.
- `length`  in  A+1  word count, 0..2^A; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the burst completes.
- `sramAddress`  out  A  drives `SRAM.address`.
- `sramWrite`  out  1  drives `SRAM.write`; constant 0.
- `sramData`  in  W  from `SRAM.dataOutput`; combinational read of `sramAddress`.
- `outData`  out  W  stream data.
- `outValid`  out  1  stream valid.
- `outReady`  in  1  stream ready from consumer.

## Operation
- Reset values:
  - `busy`, `done`, `outValid` = 0.
  - `outData` = 0.
  - `sramAddress` = 0.
  - `sramWrite` = 0.
  - FSM = IDLE.
  - Internal `remaining` = 0.
- FSM states: IDLE, FETCH, DRAIN, FIN.
  - IDLE: on `start`, latch `ptr <= baseAddr` and `remaining <= length`. Go to FETCH if `length != 0`, else go to FIN.
  - FETCH: the output register is free when `!outValid || outReady`. When it is free:
    - `outData <= sramData` (the word at `ptr`) and `outValid <= 1`.
    - `ptr <= ptr + 1` modulo 2^A.
    - `remaining <= remaining - 1`.
    - When the `remaining` being decremented is 1, go to DRAIN.
  - DRAIN: hold `outData` and `outValid` until `outValid && outReady`. Then set `outValid <= 0` and go to FIN.
  - FIN: `done = 1` for exactly this cycle, then return to IDLE.
- `sramAddress = ptr` at all times. In IDLE it holds the last pointer value and is not re-driven from `baseAddr`.
- Address wrap: `ptr` increments modulo 2^A. A burst with `baseAddr = 2^A-2` and `length = 4` reads addresses 2^A-2, 2^A-1, 0, 1.
- `length = 2^A` reads the full memory exactly once.
- `start` outside IDLE is ignored; no queuing.
- The block never writes: `sramWrite` is tied to 0.
- `outData` changes only on a load. It is stable while `outValid && !outReady`.
- Reset asserted mid-burst: all outputs return to their reset values immediately, because reset is asynchronous. The burst is abandoned and no `done` is produced.

## Timing
- Cycle 0: `start` is sampled high at a rising edge.
- Cycle 1: FETCH, `sramAddress = baseAddr`.
- Cycle 2: first word valid on `outData`.
- With `outReady` held high, word *k* is valid in cycle 2+k. The last word (k = N-1) is valid in cycle N+1.
- Cycle N+2: `done` is high, because the last handshake occurred in cycle N+1.
- Sustained throughput is one word per cycle. No bubble is inserted when `outReady` is continuously high.
- Backpressure: when `outReady` is low, `ptr` and `remaining` hold and the pending word is retained.
- `length = 0`: `busy` and `done` are high in cycle 1; IDLE in cycle 2.
- A new `start` is accepted in the cycle after `done`, i.e. the first IDLE cycle.
- `busy` is high in FETCH, DRAIN and FIN.

## Structure
- Shared package `sram_ctrl_pkg` holds:
  - FSM state encodings `S_IDLE`, `S_FETCH`, `S_DRAIN`, `S_FIN` (2-bit).
  - Default `A` and `W` constants shared with `SRAM` instantiations.
- One sub-module is natural: `stream_out_reg`, a W-bit valid/ready output register.
  - Ports: load, data_in, out_data, out_valid, out_ready, free.
  - The FSM, pointer and counter stay in the top module.

## Test plan
- Preload SRAM (A=7, W=16) with `mem[i] = i + 0x100`. Pulse `start` with `baseAddr = 5`, `length = 4`, and hold `outReady = 1`:
  - Outputs are 0x105, 0x106, 0x107, 0x108 in cycles 2–5.
  - `done` is high in cycle 6.
  - `sramWrite` is never 1.
- Same preload with `baseAddr = 126`, `length = 4` -> data 0x17E, 0x17F, 0x100, 0x101 (address wrap).
- `length = 3` with `outReady` toggling 1,0,0,1,0,1 -> exactly 3 handshakes carrying 0x105..0x107 in order. `outData` is stable during stalls; `done` is high the cycle after the third handshake.
- `length = 0` -> `busy` and `done` are high in cycle 1, with no `outValid` ever. A `start` issued in cycle 1 is ignored; a `start` in cycle 2 is accepted.
- `length = 128`, `baseAddr = 0` -> 128 words 0x100..0x17F back-to-back, then `done`.
- Assert `RST` asynchronously during the third word of an 8-word burst:
  - `outValid`, `busy`, `done` and `sramAddress` go to 0 without waiting for a clock edge.
  - No `done` follows.
  - A fresh `start` then runs correctly.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for SRAM client blocks: burst FSM state encoding and
// the default SRAM geometry used by SRAM instantiations.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_A = 7;
    localparam int unsigned SRAM_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register. A load always wins; otherwise a
// handshake empties the register. Data only changes on a load.
module stream_out_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         free
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= data_in;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Register can take a new word when empty or being drained this cycle.
    assign free      = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read client for the single-port SRAM: streams `length` words from
// `baseAddr` onward (address wraps) at up to one word per cycle.
module sram_burst_reader
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned A = SRAM_A,
    parameter int unsigned W = SRAM_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [A-1:0] baseAddr,
    input  logic [A:0]   length,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] sramAddress,
    output logic         sramWrite,
    input  logic [W-1:0] sramData,
    output logic [W-1:0] outData,
    output logic         outValid,
    input  logic         outReady
);

    localparam int unsigned LW = A + 1;

    state_e        state_q, state_d;
    logic [A-1:0]  ptr_q, ptr_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_c;
    logic          free_c;

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? S_FETCH : S_FIN;
                end
            end
            S_FETCH: begin
                if (free_c && (remaining_q == LW'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outValid && outReady) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath; busy/done are registered from the next state
    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        load_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d       = baseAddr;
                    remaining_d = length;
                end
            end
            S_FETCH: begin
                if (free_c) begin
                    load_c      = 1'b1;
                    ptr_d       = ptr_q + A'(1);
                    remaining_d = remaining_q - LW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    stream_out_reg #(
        .W(W)
    ) u_out (
        .clk      (CLK),
        .rst      (RST),
        .load     (load_c),
        .data_in  (sramData),
        .out_data (outData),
        .out_valid(outValid),
        .out_ready(outReady),
        .free     (free_c)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign sramAddress = ptr_q;
    assign sramWrite   = 1'b0;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a behavioural combinational SRAM
// preloaded with mem[i] = i + 0x100.
module tb_sram_burst_reader;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [6:0]  baseAddr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic [6:0]  sramAddress;
    logic        sramWrite;
    logic [15:0] sramData;
    logic [15:0] outData;
    logic        outValid;
    logic        outReady;

    logic [15:0] mem [0:127];
    int          n_checks;
    int          n_fail;
    int          wr_seen;

    sram_burst_reader #(.A(7), .W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .baseAddr   (baseAddr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .sramAddress(sramAddress),
        .sramWrite  (sramWrite),
        .sramData   (sramData),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady)
    );

    assign sramData = mem[sramAddress];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (sramWrite !== 1'b0) wr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Ready pattern for the backpressure burst, indexed by cycle after start.
    function automatic logic ready_pat(input int c);
        case (c)
            1: return 1'b0;
            2: return 1'b1;
            3: return 1'b0;
            4: return 1'b0;
            5: return 1'b1;
            6: return 1'b0;
            7: return 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_burst(input int base, input int len, input bit toggle);
        int          hs;
        int          last_hs;
        bit          was_stall;
        bit          fin;
        logic [15:0] held;
        hs        = 0;
        last_hs   = 0;
        was_stall = 1'b0;
        fin       = 1'b0;
        held      = '0;
        baseAddr  = 7'(base);
        length    = 8'(len);
        outReady  = toggle ? 1'b0 : 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("first_addr", 32'(sramAddress), 32'(base % 128));
        for (int cyc = 1; cyc <= len + 20 && !fin; cyc++) begin
            if (toggle) outReady = ready_pat(cyc);
            #1;
            if (was_stall) check("stall_hold", 32'(outData), 32'(held));
            if (done) begin
                check("done_count", 32'(hs), 32'(len));
                check("done_cycle", 32'(cyc), 32'(last_hs + 1));
                if (toggle) check("toggle_last_hs", 32'(last_hs), 32'd7);
                fin = 1'b1;
            end else begin
                check("busy", 32'(busy), 32'd1);
                if (outValid && outReady) begin
                    check("data", 32'(outData), 32'(16'h100 + 16'((base + hs) % 128)));
                    if (!toggle) check("hs_cycle", 32'(cyc), 32'(hs + 2));
                    hs++;
                    last_hs = cyc;
                end
            end
            was_stall = outValid && !outReady;
            held      = outData;
            if (!fin) tick();
        end
        if (!fin) check("done_timeout", 32'd0, 32'd1);
        outReady = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        n_checks = 0;
        n_fail   = 0;
        wr_seen  = 0;
        for (int i = 0; i < 128; i++) mem[i] = 16'(i + 16'h100);
        RST      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        length   = '0;
        outReady = 1'b1;

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        check("rst_addr", 32'(sramAddress), 32'd0);
        check("rst_write", 32'(sramWrite), 32'd0);
        RST = 1'b0;
        tick();

        // Basic burst, then address wrap, then backpressure
        run_burst(5, 4, 1'b0);
        run_burst(126, 4, 1'b0);
        run_burst(5, 3, 1'b1);

        // Zero-length burst; start during FIN ignored, accepted in next IDLE
        baseAddr = 7'd5;
        length   = 8'd0;
        start    = 1'b1;
        tick();
        #1;
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_done", 32'(done), 32'd1);
        check("len0_valid", 32'(outValid), 32'd0);
        baseAddr = 7'd50;
        length   = 8'd2;
        tick();
        #1;
        check("len0_idle_busy", 32'(busy), 32'd0);
        check("len0_idle_done", 32'(done), 32'd0);
        check("len0_ignored_addr", 32'(sramAddress), 32'd5);
        check("len0_no_valid", 32'(outValid), 32'd0);
        tick();
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_addr", 32'(sramAddress), 32'd50);
        tick();
        check("restart_w0", 32'(outData), 32'h132);
        check("restart_v0", 32'(outValid), 32'd1);
        tick();
        check("restart_w1", 32'(outData), 32'h133);
        tick();
        check("restart_done", 32'(done), 32'd1);
        check("restart_fin_valid", 32'(outValid), 32'd0);
        tick();
        check("restart_idle", 32'(busy), 32'd0);

        // Full-memory burst
        run_burst(0, 128, 1'b0);

        // Asynchronous reset during the third word of an 8-word burst
        baseAddr = 7'd10;
        length   = 8'd8;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_w2", 32'(outData), 32'h10C);
        RST = 1'b1;
        #1;
        check("arst_valid", 32'(outValid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_addr", 32'(sramAddress), 32'd0);
        check("arst_data", 32'(outData), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy || outValid) done_cnt++;
        end
        check("arst_no_done", 32'(done_cnt), 32'd0);
        run_burst(20, 5, 1'b0);

        check("never_write", 32'(wr_seen), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
